seven_segment_scanner: RTL

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

---
 rtl/seven_segment_pkg.sv | 30 +++
 rtl/hex_to_abcdefg.sv | 11 +
 rtl/seven_segment_scanner.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants for the four-digit seven-segment scanner: digit count,
// scan index width and the hex-to-segment lookup (a = bit 6 ... g = bit 0).
package seven_segment_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int NIBBLE_W   = 4;

  typedef logic [IDX_W-1:0] idx_t;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

endpackage

// File: rtl/hex_to_abcdefg.sv
// Combinational hex nibble to active-high abcdefg segment pattern.
module hex_to_abcdefg
  import seven_segment_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed four-digit hex display driver with double-buffered loads,
// anti-ghost blanking at the start of each slot and optional leading-zero blanking.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] number,
  input  logic [3:0]  dots,
  input  logic        lz_blank,
  output logic [6:0]  abcdefg,
  output logic        dp,
  output logic [3:0]  digit,
  output logic        frame
);

  localparam int              PW         = $clog2(DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]   BLANK_END  = PW'(BLANK);
  localparam idx_t            IDX_LAST   = idx_t'(NUM_DIGITS - 1);

  logic [PW-1:0] presc_q, presc_d;
  idx_t          idx_q, idx_d;
  logic [15:0]   pend_num_q, pend_num_d;
  logic [3:0]    pend_dots_q, pend_dots_d;
  logic          pend_vld_q, pend_vld_d;
  logic [15:0]   disp_num_q, disp_num_d;
  logic [3:0]    disp_dots_q, disp_dots_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    digit_q, digit_d;
  logic          frame_q, frame_d;

  logic          wrap;
  logic          boundary;
  logic          in_blank;
  logic          lz_kill;
  logic [3:0]    nibble;
  logic [6:0]    seg_raw;
  logic [NUM_DIGITS-1:0] lead_zero;

  assign wrap     = (presc_q == PRESC_LAST);
  assign boundary = wrap && (idx_q == IDX_LAST);
  assign in_blank = (presc_q < BLANK_END);
  assign nibble   = disp_num_q[{idx_q, 2'b00} +: NIBBLE_W];

  // Scan timing: prescaler wraps advance the slot; the last wrap of slot 3 is the frame boundary.
  always_comb begin
    presc_d = wrap ? '0 : presc_q + 1'b1;
    idx_d   = wrap ? idx_q + 1'b1 : idx_q;
  end

  // load is a single-cycle strobe with no back-pressure: it is always accepted,
  // lands in the pending buffer, and reaches the display only at a frame boundary
  // (a load on the boundary cycle itself goes straight through). Last load wins.
  always_comb begin
    pend_num_d  = pend_num_q;
    pend_dots_d = pend_dots_q;
    pend_vld_d  = pend_vld_q;
    disp_num_d  = disp_num_q;
    disp_dots_d = disp_dots_q;
    if (load) begin
      pend_num_d  = number;
      pend_dots_d = dots;
      pend_vld_d  = 1'b1;
    end else if (boundary) begin
      pend_vld_d  = 1'b0;
    end
    if (boundary) begin
      if (load) begin
        disp_num_d  = number;
        disp_dots_d = dots;
      end else if (pend_vld_q) begin
        disp_num_d  = pend_num_q;
        disp_dots_d = pend_dots_q;
      end
    end
  end

  // lead_zero[i] is set when nibbles i..3 of the displayed value are all zero.
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (disp_num_q[15:12] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] && (disp_num_q[i*NIBBLE_W +: NIBBLE_W] == 4'h0);
    end
  end

  assign lz_kill = lz_blank && (idx_q != '0) && lead_zero[idx_q];

  hex_to_abcdefg u_hex_to_abcdefg (
    .hex_i (nibble),
    .seg_o (seg_raw)
  );

  always_comb begin
    digit_d = in_blank ? 4'b0000 : (4'b0001 << idx_q);
    seg_d   = (in_blank || lz_kill) ? 7'b0000000 : seg_raw;
    dp_d    = !in_blank && disp_dots_q[idx_q];
    frame_d = boundary;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      pend_num_q  <= '0;
      pend_dots_q <= '0;
      pend_vld_q  <= 1'b0;
      disp_num_q  <= '0;
      disp_dots_q <= '0;
      seg_q       <= '0;
      dp_q        <= 1'b0;
      digit_q     <= '0;
      frame_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      pend_num_q  <= pend_num_d;
      pend_dots_q <= pend_dots_d;
      pend_vld_q  <= pend_vld_d;
      disp_num_q  <= disp_num_d;
      disp_dots_q <= disp_dots_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      digit_q     <= digit_d;
      frame_q     <= frame_d;
    end
  end

  assign abcdefg = seg_q;
  assign dp      = dp_q;
  assign digit   = digit_q;
  assign frame   = frame_q;

endmodule
